// File: rtl/wb_arbiter_if.sv
// rtl/wb_arbiter_if.sv - bundle types and FU-result / writeback interface for wb_arbiter
//
// wb_arbiter_pkg : exe_bundle_t (FU result, valid iff opid[15])
//                  red_bundle_t (redirect: opid = redirecting op, topid = oldest in flight)
// wb_arbiter_if  : redir  redirect bundle            (master -> slave)
//                  stall  writeback back-pressure     (master -> slave)
//                  resp   FU result slots [nfu][ewd]  (master -> slave)
//                  claim  per-slot claim [nfu][ewd]   (slave -> master)
//                  wb     registered writeback [wbw]  (slave -> master)

package wb_arbiter_pkg;
    typedef struct packed {
        logic [15:0] opid;
        logic [4:0]  rd;
        logic [31:0] data;
    } exe_bundle_t;

    typedef struct packed {
        logic [15:0] opid;
        logic [15:0] topid;
    } red_bundle_t;
endpackage

interface wb_arbiter_if #(
    parameter int nfu = 4,
    parameter int ewd = 2,
    parameter int wbw = 2
);
    wb_arbiter_pkg::red_bundle_t redir;
    logic                        stall;
    wb_arbiter_pkg::exe_bundle_t resp  [nfu][ewd];
    logic                        claim [nfu][ewd];
    wb_arbiter_pkg::exe_bundle_t wb    [wbw];

    modport master (output redir, output stall, output resp, input claim, input wb);
    modport slave  (input redir, input stall, input resp, output claim, output wb);
endinterface

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback arbiter selecting up to wbw FU results per cycle
//
// Ports:
//   clk  clock
//   rst  synchronous active-low reset
//   bus  wb_arbiter_if.slave: redir/stall/resp in, claim (combinational) / wb (registered) out
//
// Slots are scanned starting at port rr_ptr, slot 0 upward, wrapping over the ports.
// The first wbw valid slots are claimed; squashed ones still take a lane but write zeros.

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int nfu  = 4,
    parameter int ewd  = 2,
    parameter int wbw  = 2,
    parameter int opsz = 64
) (
    input  logic        clk,
    input  logic        rst,
    wb_arbiter_if.slave bus
);
    localparam int nent = nfu * ewd;
    localparam int nb   = $clog2(opsz);
    localparam int pw   = (nfu > 1) ? $clog2(nfu) : 1;

    logic [pw-1:0] rr_ptr_q, rr_ptr_d;
    exe_bundle_t   wb_q [wbw];
    exe_bundle_t   wb_d [wbw];
    logic          claim_d [nfu][ewd];

    // Only the ID bits inside the ordering window take part in the age compare.
    logic redir_unused;
    assign redir_unused = ^{bus.redir.opid[14:nb], bus.redir.topid[15:nb]};

    // True when x is strictly younger than the redirecting op, measured as distance
    // from the oldest in-flight op (topid) so that ID wrap-around is harmless.
    // The +1 is done one bit wider so a redirect at the far end of the window squashes nothing.
    function automatic logic succeed(input logic xv, input logic [nb-1:0] xid,
                                     input red_bundle_t r);
        logic [nb:0] dx;
        logic [nb:0] dr;
        dx = {1'b0, xid - r.topid[nb-1:0]};
        dr = {1'b0, r.opid[nb-1:0] - r.topid[nb-1:0]} + (nb+1)'(1);
        return r.opid[15] && xv && (dx >= dr);
    endfunction

    always_comb begin
        int lane;
        int idx;
        int p;
        int s;
        lane     = 0;
        idx      = 0;
        p        = 0;
        s        = 0;
        rr_ptr_d = rr_ptr_q;
        claim_d  = '{default: 1'b0};
        for (int i = 0; i < wbw; i++) begin
            wb_d[i] = '0;
        end
        if (rst && !bus.stall) begin
            // Walk the flattened slot list rotated by rr_ptr*ewd; idx maps back to (port, slot).
            for (int j = 0; j < nent; j++) begin
                idx = (j + int'(rr_ptr_q) * ewd) % nent;
                p   = idx / ewd;
                s   = idx % ewd;
                if (bus.resp[p][s].opid[15] && lane < wbw) begin
                    claim_d[p][s] = 1'b1;
                    wb_d[lane]    = succeed(1'b1, bus.resp[p][s].opid[nb-1:0], bus.redir)
                                    ? '0 : bus.resp[p][s];
                    lane          = lane + 1;
                    rr_ptr_d      = pw'((p + 1) % nfu);
                end
            end
        end else if (rst) begin
            // Stalled: hold writeback, but drop entries a concurrent redirect kills.
            for (int i = 0; i < wbw; i++) begin
                wb_d[i] = succeed(wb_q[i].opid[15], wb_q[i].opid[nb-1:0], bus.redir)
                          ? '0 : wb_q[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr_q <= '0;
            for (int i = 0; i < wbw; i++) begin
                wb_q[i] <= '0;
            end
        end else begin
            rr_ptr_q <= rr_ptr_d;
            for (int i = 0; i < wbw; i++) begin
                wb_q[i] <= wb_d[i];
            end
        end
    end

    for (genvar gi = 0; gi < wbw; gi++) begin : g_wb
        assign bus.wb[gi] = wb_q[gi];
    end

    for (genvar gp = 0; gp < nfu; gp++) begin : g_claim_p
        for (genvar gs = 0; gs < ewd; gs++) begin : g_claim_s
            assign bus.claim[gp][gs] = claim_d[gp][gs];
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - self-checking bench for wb_arbiter with a priority-key reference model
module tb_wb_arbiter;
    import wb_arbiter_pkg::*;

    localparam int NFU  = 4;
    localparam int EWD  = 2;
    localparam int WBW  = 2;
    localparam int OPSZ = 64;
    localparam int NENT = NFU * EWD;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_arbiter_if #(.nfu(NFU), .ewd(EWD), .wbw(WBW)) bus();

    wb_arbiter #(.nfu(NFU), .ewd(EWD), .wbw(WBW), .opsz(OPSZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int              checks = 0;
    int              errors = 0;
    exe_bundle_t     fu [NFU][EWD];
    red_bundle_t     redir_v;
    logic            stall_v;
    exe_bundle_t     exp_wb [WBW];
    exe_bundle_t     nxt_wb [WBW];
    logic [NENT-1:0] exp_claim;
    logic [NENT-1:0] dut_claim;
    int              rr;
    int              nxt_rr;
    bit              wb_known;
    int              port_grants [NFU];
    int              exp_rr_seq [4] = '{1, 2, 3, 0};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit m_succeed(input logic [15:0] x, input red_bundle_t r);
        int dx;
        int dr;
        dx = (int'(x[14:0]) - int'(r.topid[14:0])) & (OPSZ - 1);
        dr = (int'(r.opid[14:0]) - int'(r.topid[14:0])) & (OPSZ - 1);
        return r.opid[15] && x[15] && (dx >= dr + 1);
    endfunction

    function automatic exe_bundle_t mk(input logic [15:0] id);
        exe_bundle_t b;
        b.opid = id;
        b.rd   = 5'($urandom);
        b.data = $urandom;
        return b;
    endfunction

    task automatic clear_fu();
        for (int p = 0; p < NFU; p++)
            for (int s = 0; s < EWD; s++)
                fu[p][s] = '0;
    endtask

    // Reference: each valid slot has priority key = ring distance of its port from rr,
    // times ewd, plus slot index; lanes take the wbw smallest keys in ascending order.
    task automatic model_eval();
        int picked;
        int best;
        int bp;
        int bs;
        int key;
        exp_claim = '0;
        nxt_rr    = rr;
        for (int i = 0; i < WBW; i++) nxt_wb[i] = '0;
        if (!rst) begin
            nxt_rr = 0;
        end else if (stall_v) begin
            for (int i = 0; i < WBW; i++)
                nxt_wb[i] = m_succeed(exp_wb[i].opid, redir_v) ? '0 : exp_wb[i];
        end else begin
            picked = 0;
            while (picked < WBW) begin
                best = -1;
                bp   = 0;
                bs   = 0;
                for (int p = 0; p < NFU; p++)
                    for (int s = 0; s < EWD; s++)
                        if (fu[p][s].opid[15] && !exp_claim[p*EWD+s]) begin
                            key = ((p - rr + NFU) % NFU) * EWD + s;
                            if (best < 0 || key < best) begin
                                best = key;
                                bp   = p;
                                bs   = s;
                            end
                        end
                if (best < 0) break;
                exp_claim[bp*EWD+bs] = 1'b1;
                nxt_wb[picked] = m_succeed(fu[bp][bs].opid, redir_v) ? '0 : fu[bp][bs];
                nxt_rr = (bp + 1) % NFU;
                picked++;
            end
        end
    endtask

    // One clock: drive, check combinational claim and registered wb at negedge,
    // then commit the model and let the FUs retire claimed slots.
    task automatic cycle();
        bus.redir = redir_v;
        bus.stall = stall_v;
        for (int p = 0; p < NFU; p++)
            for (int s = 0; s < EWD; s++)
                bus.resp[p][s] = fu[p][s];
        model_eval();
        @(negedge clk);
        for (int p = 0; p < NFU; p++)
            for (int s = 0; s < EWD; s++)
                dut_claim[p*EWD+s] = bus.claim[p][s];
        check("claim", 64'(dut_claim), 64'(exp_claim));
        if (wb_known)
            for (int i = 0; i < WBW; i++)
                check($sformatf("wb%0d", i), 64'(bus.wb[i]), 64'(exp_wb[i]));
        @(posedge clk);
        #1;
        for (int i = 0; i < WBW; i++) exp_wb[i] = nxt_wb[i];
        rr = nxt_rr;
        if (!rst) wb_known = 1'b1;
        for (int p = 0; p < NFU; p++)
            for (int s = 0; s < EWD; s++)
                if (exp_claim[p*EWD+s]) fu[p][s] = '0;
    endtask

    initial begin
        rst      = 1'b0;
        stall_v  = 1'b0;
        redir_v  = '0;
        rr       = 0;
        wb_known = 1'b0;
        clear_fu();
        for (int i = 0; i < WBW; i++) exp_wb[i] = '0;

        cycle();
        cycle();
        check("rst_wb0", 64'(bus.wb[0].opid), 64'h0);
        check("rst_wb1", 64'(bus.wb[1].opid), 64'h0);
        rst = 1'b1;

        fu[2][0] = mk(16'h8005);
        cycle();
        check("single_claim", 64'(exp_claim), 64'h10);
        check("single_wb0", 64'(bus.wb[0].opid), 64'h8005);
        check("single_wb1", 64'(bus.wb[1].opid), 64'h0);
        check("single_rr", 64'(rr), 64'd3);

        rst = 1'b0;
        cycle();
        rst = 1'b1;
        fu[0][0] = mk(16'h8001);
        fu[1][1] = mk(16'h8002);
        fu[3][0] = mk(16'h8003);
        cycle();
        check("over_claim", 64'(exp_claim), 64'h09);
        check("over_rr", 64'(rr), 64'd2);
        check("over_wb0", 64'(bus.wb[0].opid), 64'h8001);
        check("over_wb1", 64'(bus.wb[1].opid), 64'h8002);
        cycle();
        check("over2_claim", 64'(exp_claim), 64'h40);
        check("over2_wb0", 64'(bus.wb[0].opid), 64'h8003);
        check("over2_rr", 64'(rr), 64'd0);

        for (int p = 0; p < NFU; p++) port_grants[p] = 0;
        for (int c = 0; c < 4; c++) begin
            for (int p = 0; p < NFU; p++)
                for (int s = 0; s < EWD; s++)
                    if (!fu[p][s].opid[15]) fu[p][s] = mk({1'b1, 15'(16 * c + p * EWD + s)});
            cycle();
            for (int p = 0; p < NFU; p++)
                port_grants[p] += int'(dut_claim[p*EWD]) + int'(dut_claim[p*EWD+1]);
            check($sformatf("fair_rr%0d", c), 64'(rr), 64'(exp_rr_seq[c]));
        end
        for (int p = 0; p < NFU; p++)
            check($sformatf("fair_port%0d", p), 64'(port_grants[p]), 64'd2);
        clear_fu();

        redir_v  = '{opid: 16'h8010, topid: 16'h800c};
        fu[0][0] = mk(16'h8012);
        fu[0][1] = mk(16'h800e);
        cycle();
        check("squash_claim", 64'(exp_claim), 64'h03);
        check("squash_wb0", 64'(bus.wb[0].opid), 64'h0);
        check("squash_wb1", 64'(bus.wb[1].opid), 64'h800e);
        redir_v = '0;

        fu[0][0] = mk(16'h8003);
        cycle();
        check("stall_pre_wb0", 64'(bus.wb[0].opid), 64'h8003);
        fu[0][0] = mk(16'h8004);
        stall_v  = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("stall_claim", 64'(dut_claim), 64'h0);
            check("stall_wb0", 64'(bus.wb[0].opid), 64'h8003);
        end
        stall_v = 1'b0;
        cycle();
        check("unstall_claim", 64'(exp_claim), 64'h01);
        check("unstall_wb0", 64'(bus.wb[0].opid), 64'h8004);

        fu[0][0] = mk(16'h8020);
        fu[0][1] = mk(16'h8008);
        cycle();
        stall_v = 1'b1;
        redir_v = '{opid: 16'h8010, topid: 16'h8000};
        cycle();
        check("stall_sq_wb0", 64'(bus.wb[0].opid), 64'h0);
        check("stall_sq_wb1", 64'(bus.wb[1].opid), 64'h8008);
        stall_v = 1'b0;
        redir_v = '0;

        fu[1][0] = mk(16'h8030);
        rst = 1'b0;
        cycle();
        check("rst_traffic_claim", 64'(dut_claim), 64'h0);
        check("rst_traffic_wb0", 64'(bus.wb[0].opid), 64'h0);
        check("rst_traffic_wb1", 64'(bus.wb[1].opid), 64'h0);
        check("rst_traffic_rr", 64'(rr), 64'd0);
        rst = 1'b1;
        cycle();
        check("post_rst_claim", 64'(exp_claim), 64'h04);

        clear_fu();
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < NFU; p++)
                for (int s = 0; s < EWD; s++)
                    if (!fu[p][s].opid[15] && $urandom_range(0, 99) < 40)
                        fu[p][s] = mk({1'b1, 15'($urandom)});
            stall_v = ($urandom_range(0, 99) < 20);
            redir_v.topid = {1'b1, 15'($urandom)};
            redir_v.opid  = {($urandom_range(0, 3) == 0), 15'(redir_v.topid[14:0] + 15'($urandom_range(0, 40)))};
            rst = ($urandom_range(0, 99) < 3) ? 1'b0 : 1'b1;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
